// File: rtl/shift_seq8_if.sv
// shift_seq8_if: command/result bundle between the command source and the shift sequencer.
interface shift_seq8_if #(
   parameter int AMT_W = 3
) ();
   logic             start;
   logic [1:0]       op;
   logic [7:0]       d_in;
   logic [AMT_W-1:0] amount;
   logic [7:0]       d_out;
   logic             busy;
   logic             done;

   modport master (output start, op, d_in, amount, input d_out, busy, done);
   modport slave  (input start, op, d_in, amount, output d_out, busy, done);
endinterface

// File: rtl/shift_seq8.sv
// shift_seq8: multi-cycle sequencer applying up to 3 bit positions of shift per clock
// until the full command amount is applied, then pulses done with the result.
module shift_seq8 #(
   parameter int AMT_W = 3
) (
   input logic         clk,
   input logic         reset_n,
   shift_seq8_if.slave bus
);
   localparam int STEP_MAX = 3;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nx;
   logic [7:0]       data_r, data_nx, dout_r, dout_nx, shifted;
   logic [AMT_W-1:0] rem_r, rem_nx, rem_left;
   logic [1:0]       op_r, op_nx, step;

   function automatic logic [7:0] shift8(input logic [7:0] d, input logic [1:0] o, input logic [1:0] s);
      return o == 2'b00 ? d << s :
             o == 2'b01 ? d >> s :
             o == 2'b10 ? 8'($signed(d) >>> s) :
                          (d >> s) | (d << (4'd8 - 4'(s)));
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         data_r <= '0;
         rem_r  <= '0;
         op_r   <= '0;
         dout_r <= '0;
      end else begin
         state  <= state_nx;
         data_r <= data_nx;
         rem_r  <= rem_nx;
         op_r   <= op_nx;
         dout_r <= dout_nx;
      end
   end

   always_comb begin
      state_nx = state;
      data_nx  = data_r;
      rem_nx   = rem_r;
      op_nx    = op_r;
      dout_nx  = dout_r;
      step     = rem_r > AMT_W'(STEP_MAX) ? 2'(STEP_MAX) : rem_r[1:0];
      shifted  = shift8(data_r, op_r, step);
      rem_left = rem_r - AMT_W'(step);
      case (state)
         IDLE: if (bus.start) begin
            data_nx  = bus.d_in;
            rem_nx   = bus.amount;
            op_nx    = bus.op;
            state_nx = bus.amount == '0 ? DONE : SHIFT;
            dout_nx  = bus.amount == '0 ? bus.d_in : dout_r;
         end
         SHIFT: begin
            data_nx  = shifted;
            rem_nx   = rem_left;
            state_nx = rem_left == '0 ? DONE : SHIFT;
            dout_nx  = rem_left == '0 ? shifted : dout_r;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.d_out = dout_r;
   assign bus.busy  = state != IDLE;
   assign bus.done  = state == DONE;
endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8: directed scoreboard bench for the multi-cycle shift sequencer.
module tb_shift_seq8;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_q[$];
   int         lat_q[$];

   always #5 clk = ~clk;

   shift_seq8_if #(.AMT_W(3)) bus ();
   shift_seq8 #(.AMT_W(3)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drive a command at a falling edge and return right after the accept edge
   task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic [2:0] amt);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.op     = op;
      bus.d_in   = d;
      bus.amount = amt;
      @(posedge clk);
   endtask

   task automatic send(input string tag, input logic [1:0] op, input logic [7:0] d,
                       input logic [2:0] amt, input logic [7:0] exp, input int lat);
      int k;
      logic [7:0] e;
      issue(op, d, amt);
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.op     = ~op;
      bus.d_in   = ~d;
      bus.amount = ~amt;
      k = 0;
      while (!bus.done && k < 20) begin
         chk({tag, "_busy_shift"}, 32'(bus.busy), 32'd1);
         @(negedge clk);
         k++;
      end
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_latency"}, 32'(k), 32'(lat_q.pop_front()));
      e = exp_q.pop_front();
      chk({tag, "_d_out"}, 32'(bus.d_out), 32'(e));
      chk({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
      chk({tag, "_hold"}, 32'(bus.d_out), 32'(e));
   endtask

   initial begin
      reset_n    = 1'b1;
      bus.start  = 1'b0;
      bus.op     = 2'b00;
      bus.d_in   = 8'h00;
      bus.amount = 3'd0;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_d_out", 32'(bus.d_out), 32'h00);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      send("asr5", 2'b10, 8'h96, 3'd5, 8'hFC, 2);

      // reset mid-SHIFT discards the command and clears outputs at once
      issue(2'b10, 8'h96, 3'd7);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      chk("pre_rst_d_out", 32'(bus.d_out), 32'hFC);
      reset_n = 1'b0;
      #1;
      chk("midrst_d_out", 32'(bus.d_out), 32'h00);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      send("post_rst", 2'b00, 8'h03, 3'd2, 8'h0C, 1);

      send("lsl7", 2'b00, 8'h81, 3'd7, 8'h80, 3);
      send("lsr7", 2'b01, 8'h81, 3'd7, 8'h01, 3);
      send("ror4", 2'b11, 8'h81, 3'd4, 8'h18, 2);
      send("zero", 2'b10, 8'h5A, 3'd0, 8'h5A, 0);
      send("asr3", 2'b10, 8'h80, 3'd3, 8'hF0, 1);
      send("ror7", 2'b11, 8'h01, 3'd7, 8'h02, 3);

      // start pulses during SHIFT and DONE are ignored; held start is taken on the first IDLE edge
      issue(2'b01, 8'hF0, 3'd6);
      exp_q.push_back(8'h03);
      @(negedge clk);
      chk("col_busy", 32'(bus.busy), 32'd1);
      bus.d_in   = 8'h0F;
      bus.amount = 3'd1;
      @(negedge clk);
      chk("col_shift_ignored", 32'(bus.done), 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      chk("col_done", 32'(bus.done), 32'd1);
      chk("col_d_out", 32'(bus.d_out), 32'(exp_q.pop_front()));
      bus.start = 1'b1;
      @(negedge clk);
      chk("col_single_pulse", 32'(bus.done), 32'd0);
      chk("col_done_ignored", 32'(bus.busy), 32'd0);
      chk("col_hold", 32'(bus.d_out), 32'h03);
      exp_q.push_back(8'h07);
      @(negedge clk);
      chk("held_accept", 32'(bus.busy), 32'd1);
      chk("held_no_done", 32'(bus.done), 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      chk("held_done", 32'(bus.done), 32'd1);
      chk("held_d_out", 32'(bus.d_out), 32'(exp_q.pop_front()));
      @(negedge clk);
      chk("held_pulse", 32'(bus.done), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
